// File: rtl/mu0_mmio_bridge.sv
// mu0_mmio_bridge: sits between the MU0 data port and the dual-port RAM.
// A 4-word window at MMIO_BASE is served locally (output FIFO, status,
// cycle counter); every other address goes straight to the RAM. MMIO reads
// are registered so they arrive with the same one-cycle latency as RAM reads.
module mu0_mmio_bridge #(
    parameter logic [11:0] MMIO_BASE  = 12'hFF0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] address,
    input  logic        write,
    input  logic        read,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [11:0] address2,
    output logic [15:0] readdata2,
    output logic [11:0] ram_address,
    output logic [11:0] ram_address2,
    output logic        ram_write,
    output logic        ram_read,
    output logic [15:0] ram_writedata,
    input  logic [15:0] ram_readdata,
    input  logic [15:0] ram_readdata2,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    // decode and handshake
    logic             mmio_hit_s;
    logic [1:0]       offset_s;
    logic             wr_data_sel_s;
    logic             wr_stat_sel_s;
    logic             push_s;
    logic             pop_s;

    // FIFO state
    logic [15:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [4:0]       count_r;
    logic [4:0]       count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             out_valid_r;
    logic [15:0]      out_data_r;
    logic [15:0]      head_nxt_s;

    // register file / read path
    logic [15:0]      cycles_r;
    logic [15:0]      status_s;
    logic [15:0]      mmio_val_s;
    logic [15:0]      mmio_rdata_r;
    logic             sel_mmio_r;

    // RAM and fetch ports are pass-through; strobes are masked inside the window
    assign ram_address   = address;
    assign ram_writedata = writedata;
    assign ram_write     = write & ~mmio_hit_s;
    assign ram_read      = read & ~mmio_hit_s;
    assign ram_address2  = address2;
    assign readdata2     = ram_readdata2;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign readdata  = sel_mmio_r ? mmio_rdata_r : ram_readdata;

    // address decode and FIFO push/pop qualification
    always_comb begin
        mmio_hit_s    = (address[11:2] == MMIO_BASE[11:2]);
        offset_s      = address[1:0];
        wr_data_sel_s = write & mmio_hit_s & (offset_s == 2'd0);
        wr_stat_sel_s = write & mmio_hit_s & (offset_s == 2'd1);
        pop_s         = out_valid_r & out_ready;
        // a full FIFO still accepts a word when the head leaves on the same edge
        push_s        = wr_data_sel_s & (~full_r | pop_s);
    end

    // next FIFO state, sticky overflow, and the word that becomes the new head
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = ovf_r;
        head_nxt_s   = out_data_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 5'd1;
            2'b01:   count_nxt_s = count_r - 5'd1;
            default: count_nxt_s = count_r;
        endcase

        if (wr_stat_sel_s) begin
            ovf_nxt_s = 1'b0;
        end else if (wr_data_sel_s && !push_s) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        // the head slot may be the one being written this edge (empty, or one
        // entry with simultaneous push/pop), so bypass the incoming word then
        if (count_nxt_s == 5'd0) begin
            head_nxt_s = out_data_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = writedata;
        end else begin
            head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
        end
    end

    // value of the addressed MMIO register before this edge
    always_comb begin
        status_s = {7'b0, count_r, 1'b0, ovf_r, empty_r, full_r};
        case (offset_s)
            2'd1:    mmio_val_s = status_s;
            2'd2:    mmio_val_s = cycles_r;
            default: mmio_val_s = 16'h0000;
        endcase
    end

    // FIFO storage; contents need no reset since pointers/count define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= writedata;
        end
    end

    // FIFO control, registered flags and registered stream head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= 5'd0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            empty_r     <= (count_nxt_s == 5'd0);
            ovf_r       <= ovf_nxt_s;
            out_valid_r <= (count_nxt_s != 5'd0);
            out_data_r  <= head_nxt_s;
        end
    end

    // free-running cycle counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_r <= 16'h0000;
        end else begin
            cycles_r <= cycles_r + 16'd1;
        end
    end

    // capture read source and MMIO data on every read edge, hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_mmio_r   <= 1'b0;
            mmio_rdata_r <= 16'h0000;
        end else if (read) begin
            sel_mmio_r   <= mmio_hit_s;
            mmio_rdata_r <= mmio_hit_s ? mmio_val_s : 16'h0000;
        end else begin
            sel_mmio_r   <= sel_mmio_r;
            mmio_rdata_r <= mmio_rdata_r;
        end
    end

endmodule

// File: tb/tb_mu0_mmio_bridge.sv
// Directed bench for mu0_mmio_bridge with a behavioural 16x4096 RAM that has
// one-cycle pipelined reads on both ports.
module tb_mu0_mmio_bridge;

    logic        clk;
    logic        rst;
    logic [11:0] address;
    logic        write;
    logic        read;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [11:0] address2;
    logic [15:0] readdata2;
    logic [11:0] ram_address;
    logic [11:0] ram_address2;
    logic        ram_write;
    logic        ram_read;
    logic [15:0] ram_writedata;
    logic [15:0] ram_readdata;
    logic [15:0] ram_readdata2;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [15:0] ram_mem [4096];

    mu0_mmio_bridge #(.MMIO_BASE(12'hFF0), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .write         (write),
        .read          (read),
        .writedata     (writedata),
        .readdata      (readdata),
        .address2      (address2),
        .readdata2     (readdata2),
        .ram_address   (ram_address),
        .ram_address2  (ram_address2),
        .ram_write     (ram_write),
        .ram_read      (ram_read),
        .ram_writedata (ram_writedata),
        .ram_readdata  (ram_readdata),
        .ram_readdata2 (ram_readdata2),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, one-cycle registered read on both ports
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_address] <= ram_writedata;
        if (ram_read)  ram_readdata <= ram_mem[ram_address];
        ram_readdata2 <= ram_mem[ram_address2];
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0;
        read  = 1'b0;
    endtask

    // one-cycle MMIO/RAM write
    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        address = a; writedata = d; write = 1'b1; read = 1'b0;
        tick();
        idle();
    endtask

    // issue a read, then compare the data presented in the following cycle
    task automatic read_check(input string tag, input logic [11:0] a, input logic [15:0] exp);
        address = a; read = 1'b1; write = 1'b0;
        tick();
        idle();
        check(tag, readdata, exp);
    endtask

    initial begin
        rst = 1'b0; address = 12'h000; write = 1'b0; read = 1'b0;
        writedata = 16'h0000; address2 = 12'h000; out_ready = 1'b0;

        // reset state
        tick(); tick();
        check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        check("rst_out_data", out_data, 16'h0000);
        address = 12'hFF0; write = 1'b1;
        #1;
        check("rst_ram_write_mmio", {15'b0, ram_write}, 16'h0000);
        write = 1'b0;
        rst = 1'b1;
        read_check("cycles_first_edge", 12'hFF2, 16'h0000);

        // RAM pass-through
        address = 12'h010; writedata = 16'h1234; write = 1'b1;
        #1;
        check("ram_write_strobe", {15'b0, ram_write}, 16'h0001);
        check("ram_address", {4'b0, ram_address}, 16'h0010);
        check("ram_writedata", ram_writedata, 16'h1234);
        tick();
        idle();
        address = 12'h010; read = 1'b1;
        #1;
        check("ram_read_strobe", {15'b0, ram_read}, 16'h0001);
        tick();
        idle();
        check("ram_readback", readdata, 16'h1234);
        address = 12'hFF1; read = 1'b1;
        #1;
        check("ram_read_masked", {15'b0, ram_read}, 16'h0000);
        tick();
        idle();
        check("status_idle", readdata, 16'h0002);
        address2 = 12'h010;
        #1;
        check("ram_address2", {4'b0, ram_address2}, 16'h0010);
        tick();
        check("fetch_readdata2", readdata2, 16'h1234);

        // reserved offsets read as zero, reserved write ignored
        do_write(12'hFF3, 16'hFFFF);
        read_check("reserved_read", 12'hFF3, 16'h0000);
        read_check("outdata_read", 12'hFF0, 16'h0000);
        read_check("status_after_rsvd_wr", 12'hFF1, 16'h0002);

        // FIFO ordering with no fall-through
        out_ready = 1'b0;
        do_write(12'hFF0, 16'hAAAA);
        check("push_valid", {15'b0, out_valid}, 16'h0001);
        check("push_head", out_data, 16'hAAAA);
        do_write(12'hFF0, 16'hBBBB);
        do_write(12'hFF0, 16'hCCCC);
        read_check("status_three", 12'hFF1, 16'h0030);
        out_ready = 1'b1;
        #1;
        check("drain0", out_data, 16'hAAAA);
        tick();
        check("drain1", out_data, 16'hBBBB);
        tick();
        check("drain2", out_data, 16'hCCCC);
        tick();
        check("drain_empty", {15'b0, out_valid}, 16'h0000);
        read_check("status_drained", 12'hFF1, 16'h0002);

        // overflow: ninth write dropped, sticky flag, cleared by STATUS write
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_write(12'hFF0, 16'h1000 + 16'(i));
        read_check("status_overflow", 12'hFF1, 16'h0085);
        address = 12'hFF1; writedata = 16'h0000; write = 1'b1; read = 1'b1;
        tick();
        idle();
        check("rw_same_cycle", readdata, 16'h0085);
        read_check("status_ovf_clear", 12'hFF1, 16'h0081);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), out_data, 16'h1000 + 16'(i));
            tick();
        end
        check("ovf_ninth_absent", {15'b0, out_valid}, 16'h0000);

        // full FIFO with pop on the same edge as a push
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(12'hFF0, 16'h2000 + 16'(i));
        out_ready = 1'b1;
        do_write(12'hFF0, 16'h2008);
        out_ready = 1'b0;
        read_check("status_full_pop", 12'hFF1, 16'h0081);
        out_ready = 1'b1;
        #1;
        for (int i = 1; i < 9; i++) begin
            check($sformatf("full_drain%0d", i), out_data, 16'h2000 + 16'(i));
            tick();
        end
        check("full_drain_empty", {15'b0, out_valid}, 16'h0000);

        // asynchronous reset mid-operation discards FIFO contents
        out_ready = 1'b0;
        do_write(12'hFF0, 16'h5555);
        rst = 1'b0;
        #1;
        check("midrst_valid", {15'b0, out_valid}, 16'h0000);
        check("midrst_data", out_data, 16'h0000);
        rst = 1'b1;
        read_check("midrst_status", 12'hFF1, 16'h0002);

        // counter wrap: 65536 edges after release, then read two edges in a row
        rst = 1'b0;
        #1;
        rst = 1'b1;
        repeat (65536) tick();
        address = 12'hFF2; read = 1'b1;
        tick();
        check("cycles_wrap", readdata, 16'h0000);
        tick();
        idle();
        check("cycles_after_wrap", readdata, 16'h0001);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mu0_mmio_bridge.md
# mu0_mmio_bridge

Memory-mapped I/O bridge placed between the MU0 CPU data port and the 16x4096 dual-port RAM with one-cycle pipelined reads. It decodes a small block of addresses at the top of the 12-bit space and serves them locally: an output FIFO drained by a valid/ready stream, a status register and a free-running cycle counter. All other addresses pass through to the RAM unchanged. Read latency seen by the CPU is identical for RAM and MMIO addresses, so the CPU needs no changes.

## Interface
- MMIO_BASE, 12'hFF0: base of the 4-word MMIO window; must be 4-aligned.
- FIFO_DEPTH, 8: output FIFO entries; power of two, 2..16.
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- address  in  12  CPU data address
- write  in  1  CPU write strobe
- read  in  1  CPU read strobe
- writedata  in  16  CPU write data
- readdata  out  16  data returned to CPU, one cycle after read
- address2  in  12  CPU fetch address, passed straight to ram_address2
- readdata2  out  16  fetch data, passed straight from ram_readdata2
- ram_address, ram_address2  out  12  RAM addresses
- ram_write, ram_read  out  1  RAM strobes, gated off for MMIO addresses
- ram_writedata  out  16  = writedata
- ram_readdata, ram_readdata2  in  16  RAM read data
- out_valid  out  1  FIFO head valid
- out_data  out  16  FIFO head word
- out_ready  in  1  downstream accepts head when high with out_valid

## Operation
- Decode: mmio_hit = (address[11:2] == MMIO_BASE[11:2]). Offsets: 0 OUT_DATA (W), 1 STATUS (R/W), 2 CYCLES (R), 3 reserved (reads 0, writes ignored).
- RAM path: ram_address = address, ram_writedata = writedata; ram_write = write & ~mmio_hit, ram_read = read & ~mmio_hit. Fetch port is pure pass-through.
- Read path: on an edge where read is high, register sel_mmio = mmio_hit and mmio_rdata (value of the addressed register at that edge). readdata = sel_mmio ? mmio_rdata : ram_readdata.
- STATUS read: bit0 full, bit1 empty, bit2 overflow (sticky), bits 8:4 occupancy count, other bits 0.
- STATUS write (any data): clears overflow.
- OUT_DATA write: push writedata if FIFO not full, or if full and a pop occurs the same cycle (out_valid & out_ready); otherwise word is dropped and overflow set.
- Pop: out_valid & out_ready removes head. Push and pop same cycle: count unchanged, ordering preserved.
- Empty FIFO with push: word appears on out_data/out_valid the following cycle (no fall-through).
- CYCLES: 16-bit counter, +1 every cycle out of reset, wraps 0xFFFF -> 0x0000.
- write and read both high: write takes effect; read still captures data (pre-write register value).

## Timing
- Reset (rst low, asynchronous): FIFO count 0, pointers 0, out_valid 0, out_data 0, overflow 0, CYCLES 0, sel_mmio 0, mmio_rdata 0. readdata therefore follows ram_readdata out of reset.
- Read issued cycle N (sampled at edge ending N): readdata valid throughout cycle N+1, held until next read edge.
- CYCLES read at edge E returns the count before the increment at E.
- STATUS read returns pre-edge state (does not reflect a push/pop on the same edge).
- FIFO full/empty flags and out_valid are registered; count/flags update on the edge of the push/pop.
- Reset asserted mid-operation: FIFO contents discarded, pending read data lost; first read after release behaves as above.

## Test plan
- Reset: hold rst=0, check out_valid=0, ram_write=0 for MMIO addresses; release, read 0xFF2 at first edge -> readdata=0x0000 next cycle.
- RAM pass-through: write 0x1234 to 0x010, read 0x010 -> ram_write=1 on write cycle, readdata=0x1234 one cycle after read; read 0xFF1 leaves ram_read=0.
- FIFO order: out_ready=0, write 0xAAAA,0xBBBB,0xCCCC to 0xFF0; STATUS read -> 0x0030; set out_ready=1 -> out_data AAAA, BBBB, CCCC on three consecutive cycles, then out_valid=0, STATUS=0x0002.
- Overflow: out_ready=0, 9 writes to 0xFF0 -> STATUS=0x0085, 9th word absent from drain; write 0xFF1 -> STATUS=0x0081.
- Full with simultaneous pop: 8 entries, out_ready=1 on same cycle as 9th write -> accepted, overflow=0, count stays 8.
- Counter wrap: run 65536 cycles after reset, read 0xFF2 at matching edge -> readdata=0x0000; read next edge -> 0x0001.
